// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Runs MULT/MULTU/DIV/DIVU one bit per cycle on operand magnitudes, then
// applies the result signs in a single FIX cycle and writes the HI/LO
// registers. MTHI/MTLO writes are accepted only while the unit is idle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    count;
    logic             last_bit;

    // acc holds {remainder, quotient} for divide, or {partial, multiplier} for multiply
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // |a| as multiplicand, or |b| as divisor
    logic [WIDTH-1:0]   a_raw;     // unmodified dividend, returned in hi on divide by zero
    logic               is_div;
    logic               neg_res;   // negate product / quotient
    logic               neg_rem;   // negate remainder

    // operand preparation at launch
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    // per-cycle step results
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    // sign-corrected results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign last_bit = (count == CW'(WIDTH - 1));

    // Magnitudes of the operands; a most-negative value maps to its unsigned magnitude.
    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_abs     = a_neg ? (~a + 1'b1) : a;
        b_abs     = b_neg ? (~b + 1'b1) : b;
    end

    // One multiply step (shift-add) and one restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (div_trial[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Apply result signs; divide by zero returns all ones and the raw dividend.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path
        // before any branch, otherwise synthesis infers a latch to hold it.
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (opnd == '0) begin
                res_lo = '1;
                res_hi = a_raw;
            end else begin
                res_lo = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
                res_hi = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of statement order.
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_bit) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath: operand latch, iteration, HI/LO writes and the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            acc     <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // start takes priority; a same-cycle MTHI/MTLO is dropped
                        count   <= '0;
                        acc     <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                        opnd    <= op[1] ? b_abs : a_abs;
                        a_raw   <= a;
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= last_bit ? '0 : count + 1'b1;
                end
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected HI/LO pairs are queued when
// an operation is launched and compared when the unit pulses done.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin p = sx * sy; return p; end
            2'd1: begin u = {32'd0, x} * {32'd0, y}; return u; end
            2'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Scoreboard consumer: compare HI/LO whenever done pulses.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check("result_hi", hi, e[63:32]);
                check("result_lo", lo, e[31:0]);
            end
        end
    end

    // Launch one op at the current negedge and follow it to done.
    // wr_cyc == 0: MTHI+MTLO together with start; wr_cyc > 0: MTLO at that busy cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int wr_cyc);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int cyc;
        old_hi = hi;
        old_lo = lo;
        op = o; a = x; b = y; start = 1'b1;
        if (wr_cyc == 0) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        sb_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom;
        cyc = 0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("hold_hi", hi, old_hi);
        check("hold_lo", lo, old_lo);
        while (!done && cyc < 40) begin
            if (wr_cyc > 0 && cyc == wr_cyc) begin
                lo_we = 1'b1; wdata = 32'h0BAD_0BAD;
            end
            @(negedge clk);
            lo_we = 1'b0;
            cyc++;
            if (!done) begin
                check("busy", busy, 1);
                if (cyc == 20 || (wr_cyc > 0 && cyc == wr_cyc + 1))
                    check("mid_hold_lo", lo, old_lo);
            end
        end
        check("latency", cyc, 33);
        check("done_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;
        @(negedge clk);

        // MTHI in idle
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 0);

        // MTHI and MTLO together
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mtboth_hi", hi, 32'hA5A5_5A5A);
        check("mtboth_lo", lo, 32'hA5A5_5A5A);

        // directed ops, back-to-back
        run_op(2'd1, 32'd7, 32'd6, -1);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, -1);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 4);
        run_op(2'd3, 32'd100, 32'd0, -1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, -1);
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, -1);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, -1);

        // random ops
        for (int i = 0; i < 6; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom, -1);
        end

        // done is a single-cycle pulse
        @(negedge clk);
        check("done_pulse", done, 0);

        // make hi/lo non-zero, then reset in the middle of a MULTU
        run_op(2'd1, 32'h0001_0003, 32'h0002_0005, -1);
        @(negedge clk);
        op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        run_op(2'd3, 32'd9, 32'd4, -1);

        repeat (40) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
